// File: rtl/icache_load_controller.sv
// Instruction-cache load sequencer.
// Stalls the front end, waits for fetch to drain, assembles a cacheline from a
// byte stream, and writes it to the i-cache. This repeats for the requested
// number of consecutive lines, after which the core is released.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no load in progress; waiting for a start command
// DRAIN  | core held; waiting for fetch to finish outstanding reads
// FILL   | core held; accepting bytes into the line buffer
// WRITE  | single-cycle i-cache write of the assembled line
// DONE   | single-cycle completion pulse; core released
module icache_load_controller #(
    parameter int LINE_BYTES = 32,
    parameter int LINE_W     = LINE_BYTES * 8,
    parameter int ADDR_W     = 5
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              startLoad_i,
    input  logic [ADDR_W-1:0] baseAddr_i,
    input  logic [ADDR_W:0]   lineCount_i,
    input  logic              abort_i,
    input  logic              fetchIdle_i,
    input  logic              byteValid_i,
    input  logic [7:0]        byteData_i,
    output logic              byteReady_o,
    output logic              coreHold_o,
    output logic              cacheWrEn_o,
    output logic [ADDR_W-1:0] cacheWrAddr_o,
    output logic [LINE_W-1:0] cacheWrData_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(LINE_BYTES);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]   LINE_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_FILL  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [CNT_W-1:0]    byte_cnt;
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   line_next;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W:0]     lines_left;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [LINE_W-1:0]   wr_data_q;

    logic                start_ok;
    logic                abort_hit;
    logic                byte_take;
    logic                last_byte;

    assign start_ok  = startLoad_i && (lineCount_i != '0);
    assign abort_hit = abort_i && (state != S_IDLE);
    assign byte_take = (state == S_FILL) && byteValid_i;
    assign last_byte = byte_take && (byte_cnt == LAST_BYTE);

    // Line buffer with the incoming byte merged in at its little-endian slot
    always_comb begin
        line_next = line_buf;
        line_next[{byte_cnt, 3'b000} +: 8] = byteData_i;
    end

    // State register
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort wins over every other transition
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (fetchIdle_i) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (last_byte) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (lines_left == LINE_ONE) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_FILL;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Byte assembly, line bookkeeping and the held write-port registers.
    // The write port gets its own copy of the line so it can hold its value
    // after the working buffer is cleared for the next line.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            byte_cnt   <= '0;
            line_buf   <= '0;
            cur_addr   <= '0;
            lines_left <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else if (abort_hit) begin
            byte_cnt <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        cur_addr   <= baseAddr_i;
                        lines_left <= lineCount_i;
                        byte_cnt   <= '0;
                        line_buf   <= '0;
                    end
                end
                S_FILL: begin
                    if (byte_take) begin
                        line_buf <= line_next;
                        byte_cnt <= byte_cnt + CNT_ONE;
                        if (last_byte) begin
                            wr_addr_q <= cur_addr;
                            wr_data_q <= line_next;
                        end
                    end
                end
                S_WRITE: begin
                    lines_left <= lines_left - LINE_ONE;
                    cur_addr   <= cur_addr + ADDR_ONE;
                    line_buf   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        byteReady_o   = (state == S_FILL);
        coreHold_o    = (state == S_DRAIN) || (state == S_FILL) || (state == S_WRITE);
        cacheWrEn_o   = (state == S_WRITE);
        busy_o        = (state != S_IDLE);
        done_o        = (state == S_DONE);
        cacheWrAddr_o = wr_addr_q;
        cacheWrData_o = wr_data_q;
    end

endmodule

// File: tb/tb_icache_load_controller.sv
// Directed bench for icache_load_controller with a write scoreboard.
module tb_icache_load_controller;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } wr_t;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              startLoad_i = 1'b0;
    logic [ADDR_W-1:0] baseAddr_i = '0;
    logic [ADDR_W:0]   lineCount_i = '0;
    logic              abort_i = 1'b0;
    logic              fetchIdle_i = 1'b0;
    logic              byteValid_i = 1'b0;
    logic [7:0]        byteData_i = '0;
    logic              byteReady_o;
    logic              coreHold_o;
    logic              cacheWrEn_o;
    logic [ADDR_W-1:0] cacheWrAddr_o;
    logic [LINE_W-1:0] cacheWrData_o;
    logic              busy_o;
    logic              done_o;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  hold_cnt = 0;
    int  wr_cyc = 0;
    int  done_cyc = 0;
    wr_t exp_q[$];

    icache_load_controller dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .startLoad_i   (startLoad_i),
        .baseAddr_i    (baseAddr_i),
        .lineCount_i   (lineCount_i),
        .abort_i       (abort_i),
        .fetchIdle_i   (fetchIdle_i),
        .byteValid_i   (byteValid_i),
        .byteData_i    (byteData_i),
        .byteReady_o   (byteReady_o),
        .coreHold_o    (coreHold_o),
        .cacheWrEn_o   (cacheWrEn_o),
        .cacheWrAddr_o (cacheWrAddr_o),
        .cacheWrData_o (cacheWrData_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc++;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe, tallies pulses
    always @(negedge clock_i) begin : mon
        wr_t e;
        if (coreHold_o) hold_cnt++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cacheWrEn_o) begin
            wr_cnt++;
            wr_cyc = cyc;
            check("sb_write_expected", LINE_W'(exp_q.size() != 0), LINE_W'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", LINE_W'(cacheWrAddr_o), LINE_W'(e.addr));
                check("wr_data", cacheWrData_o, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
        startLoad_i = 1'b1;
        baseAddr_i  = base;
        lineCount_i = cnt;
        step();
        startLoad_i = 1'b0;
    endtask

    // Offer n bytes of data, optionally with random bubbles (pct = bubble %)
    task automatic send_bytes(input logic [LINE_W-1:0] data, input int n, input int pct);
        int   k = 0;
        int   guard = 0;
        logic rdy;
        while (k < n && guard < 3000) begin
            byteValid_i = ($urandom_range(0, 99) >= pct);
            byteData_i  = data[8*k +: 8];
            @(negedge clock_i);
            rdy = byteReady_o;
            step();
            if (byteValid_i && rdy) k++;
            guard++;
        end
        byteValid_i = 1'b0;
        check("send_timeout", LINE_W'(guard < 3000), LINE_W'(1));
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  LINE_W'(busy_o), '0);
        check({tag, "_hold"},  LINE_W'(coreHold_o), '0);
        check({tag, "_wren"},  LINE_W'(cacheWrEn_o), '0);
        check({tag, "_addr"},  LINE_W'(cacheWrAddr_o), '0);
        check({tag, "_data"},  cacheWrData_o, '0);
        check({tag, "_done"},  LINE_W'(done_o), '0);
        check({tag, "_ready"}, LINE_W'(byteReady_o), '0);
    endtask

    initial begin : stim
        logic [LINE_W-1:0] d0;
        logic [LINE_W-1:0] d1;
        logic [LINE_W-1:0] d2;
        int w0;
        int d0c;
        int wt;

        // Reset state
        reset_i = 1'b0;
        step();
        step();
        @(negedge clock_i);
        check_all_zero("reset");
        step();
        reset_i = 1'b1;
        step();

        // Single line at address 0, bytes 0x00..0x1F back to back
        for (int k = 0; k < 32; k++) d0[8*k +: 8] = 8'(k);
        push_exp(5'd0, d0);
        fetchIdle_i = 1'b1;
        hold_cnt = 0;
        w0 = wr_cnt;
        d0c = done_cnt;
        start(5'd0, 6'd1);
        send_bytes(d0, 32, 0);
        @(negedge clock_i);
        check("single_wren_after_last", LINE_W'(cacheWrEn_o), LINE_W'(1));
        check("single_done_not_yet", LINE_W'(done_o), '0);
        @(negedge clock_i);
        check("single_done_pulse", LINE_W'(done_o), LINE_W'(1));
        check("single_wren_one_cycle", LINE_W'(cacheWrEn_o), '0);
        check("single_done_hold_low", LINE_W'(coreHold_o), '0);
        @(negedge clock_i);
        check("single_done_one_cycle", LINE_W'(done_o), '0);
        check("single_idle_busy", LINE_W'(busy_o), '0);
        check("single_done_after_wr", LINE_W'(done_cyc - wr_cyc), LINE_W'(1));
        check("single_hold_cycles", LINE_W'(hold_cnt), LINE_W'(34));
        check("single_wr_count", LINE_W'(wr_cnt - w0), LINE_W'(1));
        check("single_done_count", LINE_W'(done_cnt - d0c), LINE_W'(1));
        check("single_addr_held", LINE_W'(cacheWrAddr_o), '0);
        check("single_data_held", cacheWrData_o, d0);
        step();

        // Three lines starting at 31 (wraps to 0, 1); a start during FILL is ignored
        d0 = rand_line();
        d1 = rand_line();
        d2 = rand_line();
        push_exp(5'd31, d0);
        push_exp(5'd0, d1);
        push_exp(5'd1, d2);
        w0 = wr_cnt;
        d0c = done_cnt;
        start(5'd31, 6'd3);
        wt = 0;
        @(negedge clock_i);
        while (!byteReady_o && wt < 100) begin
            @(negedge clock_i);
            wt++;
        end
        check("wrap_reach_fill", LINE_W'(wt < 100), LINE_W'(1));
        step();
        start(5'd7, 6'd1);
        send_bytes(d0, 32, 0);
        send_bytes(d1, 32, 0);
        send_bytes(d2, 32, 0);
        repeat (4) step();
        @(negedge clock_i);
        check("wrap_wr_count", LINE_W'(wr_cnt - w0), LINE_W'(3));
        check("wrap_done_count", LINE_W'(done_cnt - d0c), LINE_W'(1));
        check("wrap_idle", LINE_W'(busy_o), '0);
        check("wrap_addr_held", LINE_W'(cacheWrAddr_o), LINE_W'(1));
        step();

        // Zero line count is ignored
        d0c = done_cnt;
        start(5'd3, 6'd0);
        @(negedge clock_i);
        check("zero_count_busy", LINE_W'(busy_o), '0);
        step();
        step();
        @(negedge clock_i);
        check("zero_count_busy_later", LINE_W'(busy_o), '0);
        check("zero_count_no_done", LINE_W'(done_cnt - d0c), '0);
        step();

        // Fetch not idle for 5 cycles, then a line with random bubbles
        fetchIdle_i = 1'b0;
        d0 = rand_line();
        push_exp(5'd4, d0);
        start(5'd4, 6'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_i);
            check("drain_ready_low", LINE_W'(byteReady_o), '0);
            check("drain_hold_high", LINE_W'(coreHold_o), LINE_W'(1));
            step();
        end
        fetchIdle_i = 1'b1;
        @(negedge clock_i);
        check("drain_ready_still_low", LINE_W'(byteReady_o), '0);
        step();
        @(negedge clock_i);
        check("drain_ready_rise", LINE_W'(byteReady_o), LINE_W'(1));
        step();
        w0 = wr_cnt;
        send_bytes(d0, 32, 40);
        repeat (3) step();
        check("bubble_wr_count", LINE_W'(wr_cnt - w0), LINE_W'(1));

        // Abort after byte 20 of line 2 of 4
        d0 = rand_line();
        d1 = rand_line();
        push_exp(5'd10, d0);
        w0 = wr_cnt;
        d0c = done_cnt;
        start(5'd10, 6'd4);
        send_bytes(d0, 32, 0);
        send_bytes(d1, 20, 0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        @(negedge clock_i);
        check("abort_idle", LINE_W'(busy_o), '0);
        check("abort_hold_low", LINE_W'(coreHold_o), '0);
        check("abort_ready_low", LINE_W'(byteReady_o), '0);
        repeat (40) step();
        check("abort_wr_count", LINE_W'(wr_cnt - w0), LINE_W'(1));
        check("abort_no_done", LINE_W'(done_cnt - d0c), '0);
        check("abort_addr_held", LINE_W'(cacheWrAddr_o), LINE_W'(10));

        // Reset during FILL after 10 bytes
        d0 = rand_line();
        w0 = wr_cnt;
        start(5'd2, 6'd1);
        send_bytes(d0, 10, 0);
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        @(negedge clock_i);
        check_all_zero("midreset");
        repeat (40) step();
        check("midreset_no_write", LINE_W'(wr_cnt - w0), '0);
        check("midreset_still_idle", LINE_W'(busy_o), '0);

        check("sb_drained", LINE_W'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_load_controller.md
Name: icache_load_controller

Overview:
- Single-clock sequencer that programs the instruction cache from an external byte stream. It replaces the separate-clock shift-register programming path.
- Flow: holds the front end, waits for fetch to go idle, assembles 32 bytes into one 256-bit cacheline, then issues a one-cycle write to the i-cache. Repeats for N consecutive lines, then releases the core.
- Sits between the off-core loader and the i-cache write port of PA_Core.

Parameters:
- LINE_BYTES, 32, bytes per cacheline.
- LINE_W, LINE_BYTES*8 (256), cacheline width in bits.
- ADDR_W, 5, cacheline index width (32 lines).

Ports:
- clock_i  input  1  core clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-low reset (0 = reset, sampled on the clock_i rising edge).
- startLoad_i  input  1  pulse; begins a load when the block is IDLE.
- baseAddr_i  input  ADDR_W  first cacheline index; sampled with startLoad_i.
- lineCount_i  input  ADDR_W+1  number of lines to load (0..32); sampled with startLoad_i.
- abort_i  input  1  cancels the load in progress.
- fetchIdle_i  input  1  fetch stage has no outstanding i-cache read.
- byteValid_i  input  1  loader byte valid.
- byteData_i  input  8  loader byte.
- byteReady_o  output  1  controller accepts a byte this cycle.
- coreHold_o  output  1  stalls PC/fetch while a load is active.
- cacheWrEn_o  output  1  i-cache write strobe.
- cacheWrAddr_o  output  ADDR_W  cacheline index being written.
- cacheWrData_o  output  LINE_W  assembled cacheline.
- busy_o  output  1  state is not IDLE.
- done_o  output  1  one-cycle pulse when a load completes normally.

Behaviour:
- States: IDLE, DRAIN, FILL, WRITE, DONE. All outputs are decoded from registered state and registers; there are no combinational input-to-output paths, except that byteReady_o equals (state==FILL).
- Reset (reset_i=0 at an edge) forces:
  - state IDLE, byte counter 0, line buffer 0.
  - All outputs 0, including cacheWrAddr_o and cacheWrData_o.
  - Reset mid-load abandons the load and issues no write.
- IDLE:
  - startLoad_i=1 with lineCount_i!=0: latch curAddr=baseAddr_i and linesLeft=lineCount_i, go to DRAIN.
  - lineCount_i=0: ignored; stay IDLE with no done_o pulse.
  - startLoad_i in any other state: ignored.
- DRAIN: coreHold_o=1. When fetchIdle_i=1, go to FILL on the next edge. DRAIN lasts at least one cycle even if fetchIdle_i is already 1.
- FILL:
  - coreHold_o=1, byteReady_o=1.
  - On each edge with byteValid_i=1: line[byteCnt*8 +: 8] <= byteData_i, then byteCnt++. Byte 0 goes to bits [7:0], little-endian order.
  - Bubbles (byteValid_i=0) are allowed and leave the counter unchanged.
  - When byte LINE_BYTES-1 is accepted, go to WRITE; byteCnt wraps to 0.
- WRITE (exactly one cycle):
  - cacheWrEn_o=1, cacheWrAddr_o=curAddr, cacheWrData_o=line buffer; byteReady_o=0.
  - Next edge: linesLeft--, curAddr++ (wraps modulo 2^ADDR_W, so 31 goes to 0), line buffer cleared.
  - If linesLeft was 1, go to DONE; otherwise go to FILL.
- DONE: done_o=1 for one cycle, coreHold_o=0, then IDLE.
- Latency:
  - Last byte accepted at edge N: write strobe is high in cycle N..N+1, and done_o is high in the following cycle (single-line load).
  - Minimum cost per line: 32 FILL cycles plus 1 WRITE cycle.
- abort_i:
  - Highest priority after reset.
  - Sampled =1 in DRAIN, FILL, WRITE or DONE: next state IDLE, byteCnt and buffer cleared, no done_o.
  - A write strobe already present in the WRITE cycle still stands; no further writes follow.
  - Abort in IDLE has no effect.
- coreHold_o=1 exactly in DRAIN, FILL and WRITE. busy_o=1 in every state except IDLE.
- cacheWrAddr_o and cacheWrData_o hold their last values when cacheWrEn_o=0.

Test Plan:
- Reset: drive reset_i=0 mid-FILL after 10 bytes -> next cycle all outputs 0, state IDLE, and cacheWrEn_o is never asserted.
- Single line: start with baseAddr=0, lineCount=1, fetchIdle=1, stream bytes 0x00..0x1F back-to-back -> one cacheWrEn_o pulse with addr 0 and data byte k at bits [8k+7:8k]. done_o pulses 1 cycle after the write. coreHold_o is high for 1+32+1 cycles.
- Multi-line with wrap: baseAddr=31, lineCount=3 -> writes to addresses 31, 0, 1 in order, 3 strobes, one done_o.
- Backpressure and hazard: hold fetchIdle_i=0 for 5 cycles -> byteReady_o stays 0 until 1 cycle after fetchIdle_i rises. Insert random byteValid_i bubbles -> the assembled line is unchanged.
- Abort: assert abort_i after byte 20 of line 2 of 4 -> exactly one write (line 1), no done_o, IDLE next cycle, coreHold_o=0.
- Ignored commands: lineCount=0 start -> no state change. A startLoad_i during FILL -> ignored; base and count are unchanged.
